csa_accum_resolve: RTL

- Downstream consumer of the 4:2 carry-save compression stage in the float_MAC mantissa datapath.
- Accepts pairs of partial-sum rows and accumulates them in redundant (sum/carry) form, one beat per cycle, with no carry propagation.
- On the last beat, resolves the redundant pair to a binary result over several cycles using a chunked carry-propagate adder.
- Presents the result, a beat count and an overflow flag through a valid/ready handshake.

---
 rtl/csa_accum_resolve.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/csa_accum_resolve.sv
`timescale 1ns/1ps
// Carry-save accumulator with chunked carry-propagate resolve and valid/ready output.
// Optional macro CSA_SAT_EN: saturate out_data to all ones when the group overflowed.
module csa_accum_resolve #(
    parameter int IN_W  = 8,
    parameter int AW    = 12,
    parameter int CHUNK = 4,
    parameter int CW    = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_a,
    input  logic [IN_W-1:0] in_b,
    input  logic            in_last,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [AW-1:0]   out_data,
    output logic            out_ovf,
    output logic [CW-1:0]   out_beats
);

    localparam int RES_CYC = AW / CHUNK;
    localparam int IW      = $clog2(RES_CYC + 1);

    typedef enum logic [1:0] {ST_ACC, ST_RES, ST_OUT} state_t;

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_acc_s;
    logic [AW-1:0]   r_acc_c;
    logic [AW-1:0]   r_res;
    logic            r_ovf;
    logic            r_cin;
    logic [CW-1:0]   r_beats;
    logic [IW-1:0]   r_idx;

    logic [AW-1:0]   w_a;
    logic [AW-1:0]   w_b;
    logic [AW-1:0]   w_s1;
    logic [AW-1:0]   w_c1;
    logic [AW-1:0]   w_c1_sh;
    logic [AW-1:0]   w_s2;
    logic [AW-1:0]   w_c2;
    logic            w_ovf_beat;
    logic [CHUNK:0]  w_chunk_sum;
    logic [AW-1:0]   w_res_final;
    logic            w_accept;
    logic            w_done;

    // 4:2 compressor as two chained full-adder rows; bits pushed past the MSB
    // by either carry row are exactly the weight >= 2^AW contributions.
    assign w_a        = {{(AW-IN_W){1'b0}}, in_a};
    assign w_b        = {{(AW-IN_W){1'b0}}, in_b};
    assign w_s1       = w_a ^ w_b ^ r_acc_s;
    assign w_c1       = (w_a & w_b) | (w_a & r_acc_s) | (w_b & r_acc_s);
    assign w_c1_sh    = {w_c1[AW-2:0], 1'b0};
    assign w_s2       = w_s1 ^ r_acc_c ^ w_c1_sh;
    assign w_c2       = (w_s1 & r_acc_c) | (w_s1 & w_c1_sh) | (r_acc_c & w_c1_sh);
    assign w_ovf_beat = w_c1[AW-1] | w_c2[AW-1];

    // Low chunk of the redundant pair; both registers shift right during resolve.
    assign w_chunk_sum = {1'b0, r_acc_s[CHUNK-1:0]} + {1'b0, r_acc_c[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, r_cin};

`ifdef CSA_SAT_EN
    assign w_res_final = r_ovf ? {AW{1'b1}} : r_res;
`else
    assign w_res_final = r_res;
`endif

    assign w_accept = in_valid & in_ready;
    assign w_done   = (r_idx == IW'(RES_CYC));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_ACC;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_ACC:  if (w_accept && in_last) w_next = ST_RES;
            ST_RES:  if (w_done)              w_next = ST_OUT;
            ST_OUT:  if (out_ready)           w_next = ST_ACC;
            default:                          w_next = ST_ACC;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_ACC:  in_ready  = 1'b1;
            ST_OUT:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc_s   <= '0;
            r_acc_c   <= '0;
            r_res     <= '0;
            r_ovf     <= 1'b0;
            r_cin     <= 1'b0;
            r_beats   <= '0;
            r_idx     <= '0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_beats <= '0;
        end else begin
            case (r_state)
                ST_ACC: begin
                    if (w_accept) begin
                        r_acc_s <= w_s2;
                        r_acc_c <= {w_c2[AW-2:0], 1'b0};
                        r_ovf   <= r_ovf | w_ovf_beat;
                        r_beats <= (&r_beats) ? r_beats : r_beats + CW'(1);
                        if (in_last) begin
                            r_idx <= '0;
                            r_cin <= 1'b0;
                        end
                    end
                end
                ST_RES: begin
                    if (!w_done) begin
                        r_acc_s <= r_acc_s >> CHUNK;
                        r_acc_c <= r_acc_c >> CHUNK;
                        r_res   <= {w_chunk_sum[CHUNK-1:0], r_res[AW-1:CHUNK]};
                        r_cin   <= w_chunk_sum[CHUNK];
                        r_idx   <= r_idx + IW'(1);
                        if (r_idx == IW'(RES_CYC - 1))
                            r_ovf <= r_ovf | w_chunk_sum[CHUNK];
                    end else begin
                        out_data  <= w_res_final;
                        out_ovf   <= r_ovf;
                        out_beats <= r_beats;
                    end
                end
                ST_OUT: begin
                    if (out_ready) begin
                        r_acc_s <= '0;
                        r_acc_c <= '0;
                        r_ovf   <= 1'b0;
                        r_beats <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
